ui_level_ctrl: RTL and testbench

//  Multi-button user-control front end for the board top. Per-button 2-FF sync, debounce,

---
 rtl/ui_level_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ui_level_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ui_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ui_level_ctrl
// Brief    : Button front end for the board top. Each button gets a 2-FF
//            synchroniser, a debounce filter, and press / long-press pulse
//            detection. A level selector is driven from the pulses: button 0
//            steps up, button 1 steps down, and a long press of button 0
//            returns to level 0. The level picks noise_magnitude from a table.
// Revision : 1.0 - initial release
// ============================================================================
module ui_level_ctrl #(
    parameter int N_BTN          = 2,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int DEB_CYCLES     = 540000,
    parameter int LONG_CYCLES    = 27000000,
    parameter int NUM_LEVELS     = 4,
    parameter int MAG_WIDTH      = 8,
    parameter logic [NUM_LEVELS*MAG_WIDTH-1:0] LEVEL_TABLE = {8'd100, 8'd50, 8'd20, 8'd0},
    parameter int WRAP           = 1,
    localparam int LVL_W         = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BTN-1:0]     btn_raw,
    output logic [N_BTN-1:0]     btn_level,
    output logic [N_BTN-1:0]     btn_press,
    output logic [N_BTN-1:0]     btn_long,
    output logic [LVL_W-1:0]     level_sel,
    output logic [MAG_WIDTH-1:0] noise_magnitude,
    output logic                 level_changed
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  c_deb_max  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] c_long_max = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LVL_W-1:0]  c_lvl_max  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LVL_W-1:0]  c_lvl_zero = '0;
    localparam logic [MAG_WIDTH-1:0] c_mag_rst = LEVEL_TABLE[MAG_WIDTH-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FIRED = 2'd2
    } long_state_t;

    // ------------------------------------------------------------------
    // Polarity normalisation: internally 1 always means pressed
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] w_btn_norm;
    logic [N_BTN-1:0] r_s0;
    logic [N_BTN-1:0] r_s1;

    generate
        if (BTN_ACTIVE_LOW != 0) begin : g_pol_low
            assign w_btn_norm = ~btn_raw;
        end else begin : g_pol_high
            assign w_btn_norm = btn_raw;
        end
    endgenerate

    // Two-flop synchroniser for all raw button pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else begin
            r_s0 <= w_btn_norm;
            r_s1 <= r_s0;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce, press pulse and long-press detection
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_btn
            logic [DEB_W-1:0]  r_deb_cnt;
            logic              r_stable;
            logic              r_level;
            logic              r_press;
            long_state_t       r_state;
            long_state_t       w_state_nxt;
            logic [LONG_W-1:0] r_hold_cnt;
            logic [LONG_W-1:0] w_hold_nxt;
            logic              w_long;

            // Accept a new input state only after it persists for DEB_CYCLES
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_deb_cnt <= '0;
                    r_stable  <= 1'b0;
                end else if (r_s1[i] != r_stable) begin
                    if (r_deb_cnt == c_deb_max) begin
                        r_stable  <= r_s1[i];
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end else begin
                    r_deb_cnt <= '0;
                end
            end

            // Output stage: level and its rising-edge pulse land on the same edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_level <= r_stable;
                    r_press <= r_stable & ~r_level;
                end
            end

            // Long-press state and hold counter registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state    <= ST_IDLE;
                    r_hold_cnt <= '0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_hold_cnt <= w_hold_nxt;
                end
            end

            // Long-press next state; the pulse is decoded from the terminal count
            always_comb begin
                w_state_nxt = r_state;
                w_hold_nxt  = r_hold_cnt;
                w_long      = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (r_press) begin
                            w_state_nxt = ST_HOLD;
                            w_hold_nxt  = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!r_level) begin
                            w_state_nxt = ST_IDLE;
                            w_hold_nxt  = '0;
                        end else if (r_hold_cnt == c_long_max) begin
                            w_long      = 1'b1;
                            w_state_nxt = ST_FIRED;
                        end else begin
                            w_hold_nxt  = r_hold_cnt + 1'b1;
                        end
                    end
                    ST_FIRED: begin
                        if (!r_level) begin
                            w_state_nxt = ST_IDLE;
                            w_hold_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                    end
                endcase
            end

            assign btn_level[i] = r_level;
            assign btn_press[i] = r_press;
            assign btn_long[i]  = w_long;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Level selector
    // ------------------------------------------------------------------
    logic                 w_up;
    logic                 w_down;
    logic                 w_home;
    logic [LVL_W-1:0]     w_lvl_nxt;
    logic [LVL_W-1:0]     r_level_sel;
    logic [MAG_WIDTH-1:0] r_mag;
    logic                 r_changed;
    logic [MAG_WIDTH-1:0] w_table [NUM_LEVELS];

    assign w_up   = btn_press[0];
    assign w_home = btn_long[0];

    generate
        if (N_BTN >= 2) begin : g_down
            assign w_down = btn_press[1];
        end else begin : g_no_down
            assign w_down = 1'b0;
        end
        for (genvar j = 0; j < NUM_LEVELS; j++) begin : g_table
            assign w_table[j] = LEVEL_TABLE[j*MAG_WIDTH +: MAG_WIDTH];
        end
    endgenerate

    // Next level: home has priority, simultaneous up+down cancel out
    always_comb begin
        w_lvl_nxt = r_level_sel;
        if (w_home) begin
            w_lvl_nxt = c_lvl_zero;
        end else if (w_up && w_down) begin
            w_lvl_nxt = r_level_sel;
        end else if (w_up) begin
            if (r_level_sel == c_lvl_max) begin
                w_lvl_nxt = (WRAP != 0) ? c_lvl_zero : r_level_sel;
            end else begin
                w_lvl_nxt = r_level_sel + 1'b1;
            end
        end else if (w_down) begin
            if (r_level_sel == c_lvl_zero) begin
                w_lvl_nxt = (WRAP != 0) ? c_lvl_max : r_level_sel;
            end else begin
                w_lvl_nxt = r_level_sel - 1'b1;
            end
        end
    end

    // Level, magnitude lookup and change pulse all update on one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_sel <= c_lvl_zero;
            r_mag       <= c_mag_rst;
            r_changed   <= 1'b0;
        end else begin
            r_level_sel <= w_lvl_nxt;
            r_mag       <= w_table[w_lvl_nxt];
            r_changed   <= (w_lvl_nxt != r_level_sel);
        end
    end

    assign level_sel       = r_level_sel;
    assign noise_magnitude = r_mag;
    assign level_changed   = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_ui_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ui_level_ctrl
// Brief    : Directed bench for ui_level_ctrl with short debounce/long-press
//            timing. A wrapping and a saturating instance share the inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ui_level_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] btn_raw;

    logic [1:0] lvl_a, prs_a, lng_a, lvl_b, prs_b, lng_b;
    logic [1:0] sel_a, sel_b;
    logic [7:0] mag_a, mag_b;
    logic       chg_a, chg_b;

    int n_checks = 0;
    int n_err    = 0;

    logic [1:0] pr;
    logic       ca, cb;
    int exp_mag_a [4] = '{20, 50, 100, 0};
    int exp_mag_b [4] = '{20, 50, 100, 100};
    int exp_chg_b [4] = '{1, 1, 1, 0};

    ui_level_ctrl #(
        .N_BTN(2), .BTN_ACTIVE_LOW(1), .DEB_CYCLES(4), .LONG_CYCLES(20),
        .NUM_LEVELS(4), .MAG_WIDTH(8), .LEVEL_TABLE({8'd100, 8'd50, 8'd20, 8'd0}), .WRAP(1)
    ) u_wrap (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_long(lng_a),
        .level_sel(sel_a), .noise_magnitude(mag_a), .level_changed(chg_a)
    );

    ui_level_ctrl #(
        .N_BTN(2), .BTN_ACTIVE_LOW(1), .DEB_CYCLES(4), .LONG_CYCLES(20),
        .NUM_LEVELS(4), .MAG_WIDTH(8), .LEVEL_TABLE({8'd100, 8'd50, 8'd20, 8'd0}), .WRAP(0)
    ) u_sat (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_long(lng_b),
        .level_sel(sel_b), .noise_magnitude(mag_b), .level_changed(chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    // Press the masked buttons (active low) long enough for one press pulse,
    // capture the press pulse and change flags, then release and settle.
    task automatic press(input logic [1:0] mask, output logic [1:0] p,
                         output logic c_a, output logic c_b);
        btn_raw = btn_raw & ~mask;
        repeat (7) tick();
        p = prs_a;
        tick();
        c_a = chg_a;
        c_b = chg_b;
        btn_raw = btn_raw | mask;
        repeat (12) tick();
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 2'b11;
        repeat (3) tick();

        // Reset state
        check("rst_sel_a", 32'(sel_a), 0);
        check("rst_mag_a", 32'(mag_a), 0);
        check("rst_lvl_a", 32'(lvl_a), 0);
        check("rst_pulses_a", 32'({prs_a, lng_a, chg_a}), 0);
        check("rst_sel_b", 32'(sel_b), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Glitch of 3 cycles is filtered
        btn_raw[0] = 1'b0;
        repeat (3) tick();
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("glitch_lvl", 32'(lvl_a[0]), 0);
            check("glitch_press", 32'(prs_a[0]), 0);
        end
        check("glitch_sel", 32'(sel_a), 0);

        // Held press: level rises DEB+2 edges after first sampling edge
        btn_raw[0] = 1'b0;
        repeat (6) tick();
        check("deb_lvl_early", 32'(lvl_a[0]), 0);
        tick();
        check("deb_lvl", 32'(lvl_a[0]), 1);
        check("deb_press", 32'(prs_a[0]), 1);
        check("deb_sel_before", 32'(sel_a), 0);
        tick();
        check("step_sel_a", 32'(sel_a), 1);
        check("step_mag_a", 32'(mag_a), 20);
        check("step_chg_a", 32'(chg_a), 1);
        check("step_press_gone", 32'(prs_a[0]), 0);
        check("step_sel_b", 32'(sel_b), 1);
        check("step_chg_b", 32'(chg_b), 1);
        btn_raw[0] = 1'b1;
        repeat (12) tick();
        check("release_sel", 32'(sel_a), 1);
        check("release_lvl", 32'(lvl_a[0]), 0);
        check("release_chg", 32'(chg_a), 0);

        // Four up presses from level 0: wrap vs saturate
        do_reset();
        for (int n = 0; n < 4; n++) begin
            press(2'b01, pr, ca, cb);
            check("up_mag_a", 32'(mag_a), exp_mag_a[n]);
            check("up_chg_a", 32'(ca), 1);
            check("up_mag_b", 32'(mag_b), exp_mag_b[n]);
            check("up_chg_b", 32'(cb), exp_chg_b[n]);
        end
        check("up_sel_b_sat", 32'(sel_b), 3);

        // Down at level 0
        do_reset();
        press(2'b10, pr, ca, cb);
        check("dn0_sel_a", 32'(sel_a), 3);
        check("dn0_mag_a", 32'(mag_a), 100);
        check("dn0_chg_a", 32'(ca), 1);
        check("dn0_sel_b", 32'(sel_b), 0);
        check("dn0_mag_b", 32'(mag_b), 0);
        check("dn0_chg_b", 32'(cb), 0);
        press(2'b10, pr, ca, cb);
        check("dn_sel_a", 32'(sel_a), 2);
        check("dn_mag_a", 32'(mag_a), 50);

        // Simultaneous up and down cancel
        press(2'b11, pr, ca, cb);
        check("both_press", 32'(pr), 3);
        check("both_sel_a", 32'(sel_a), 2);
        check("both_chg_a", 32'(ca), 0);
        check("both_sel_b", 32'(sel_b), 0);
        check("both_chg_b", 32'(cb), 0);

        // Long press: step to 1, then home to 0 twenty cycles after press
        do_reset();
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("long_a", 32'(lng_a[0]), 32'(k == 26));
            check("long_b", 32'(lng_b[0]), 32'(k == 26));
            if (k == 6) check("long_press", 32'(prs_a[0]), 1);
            if (k == 7) check("long_sel1", 32'(sel_a), 1);
            if (k == 27) begin
                check("long_sel0", 32'(sel_a), 0);
                check("long_mag0", 32'(mag_a), 0);
                check("long_chg", 32'(chg_a), 1);
            end
        end
        btn_raw[0] = 1'b1;
        repeat (12) tick();
        check("long_after_sel", 32'(sel_a), 0);

        // Reset in the middle of a hold
        btn_raw[0] = 1'b0;
        repeat (12) tick();
        check("midhold_sel", 32'(sel_a), 1);
        rst = 1'b1;
        #1;
        check("midrst_sel", 32'(sel_a), 0);
        check("midrst_mag", 32'(mag_a), 0);
        check("midrst_lvl", 32'(lvl_a), 0);
        check("midrst_pulses", 32'({prs_a, lng_a, chg_a}), 0);
        btn_raw[0] = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("post_rst_quiet", 32'({lvl_a, prs_a, lng_a, chg_a}), 0);
        end
        check("post_rst_sel", 32'(sel_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
